// File: rtl/cpu_control_if.sv
// Memory bus between the SRM controller and instruction/data memory.
// The controller issues mem_cmd/mem_addr; memory returns mem_rdata one cycle later.
interface cpu_control_if;
  logic [1:0]  mem_cmd;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;

  modport master (output mem_cmd, output mem_addr, input mem_rdata);
  modport slave  (input mem_cmd, input mem_addr, output mem_rdata);
endinterface

// File: rtl/cpu_control.sv
// Fetch/decode/sequencing controller for the Simple RISC Machine.
// Moore FSM owning PC, IR and the load/store data-address register.
module cpu_control (
  input  logic                 clk,
  input  logic                 reset,
  cpu_control_if.master        bus,
  input  logic [15:0]          datapath_out,
  output logic [7:0]           PC,
  output logic [2:0]           readnum,
  output logic [2:0]           writenum,
  output logic [3:0]           vsel,
  output logic                 loada,
  output logic                 loadb,
  output logic                 loadc,
  output logic                 loads,
  output logic                 write,
  output logic                 asel,
  output logic                 bsel,
  output logic                 sximmsel,
  output logic [1:0]           shift,
  output logic [1:0]           ALUop,
  output logic [15:0]          sximm8,
  output logic [15:0]          sximm5,
  output logic                 halted
);
  localparam logic [3:0] S_RST   = 4'd0;
  localparam logic [3:0] S_IF1   = 4'd1;
  localparam logic [3:0] S_IF2   = 4'd2;
  localparam logic [3:0] S_DEC   = 4'd3;
  localparam logic [3:0] S_WIMM  = 4'd4;
  localparam logic [3:0] S_GETA  = 4'd5;
  localparam logic [3:0] S_GETB  = 4'd6;
  localparam logic [3:0] S_ALU   = 4'd7;
  localparam logic [3:0] S_WREG  = 4'd8;
  localparam logic [3:0] S_ADDR  = 4'd9;
  localparam logic [3:0] S_LADDR = 4'd10;
  localparam logic [3:0] S_RD1   = 4'd11;
  localparam logic [3:0] S_RD2   = 4'd12;
  localparam logic [3:0] S_STC   = 4'd13;
  localparam logic [3:0] S_WR    = 4'd14;
  localparam logic [3:0] S_HALT  = 4'd15;

  logic [3:0]  state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  da_q, da_d;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  logic       is_movi, is_movr, is_alu, is_cmp, is_mvn, is_ldr, is_str;

  // Only the low byte of C forms an address.
  logic unused_dp_hi;
  assign unused_dp_hi = ^datapath_out[15:8];

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  assign is_movi = (opcode == 3'b110) && (op == 2'b10);
  assign is_movr = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu  = (opcode == 3'b101);
  assign is_cmp  = is_alu && (op == 2'b01);
  assign is_mvn  = is_alu && (op == 2'b11);
  assign is_ldr  = (opcode == 3'b011) && (op == 2'b00);
  assign is_str  = (opcode == 3'b100) && (op == 2'b00);

  assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
  assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};
  assign PC     = pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    da_d    = da_q;
    case (state_q)
      S_RST:   state_d = S_IF1;
      S_IF1:   state_d = S_IF2;
      S_IF2: begin
        ir_d    = bus.mem_rdata;
        pc_d    = pc_q + 8'd1;
        state_d = S_DEC;
      end
      S_DEC: begin
        if (is_movi)                 state_d = S_WIMM;
        else if (is_movr || is_mvn)  state_d = S_GETB;
        else if (is_alu)             state_d = S_GETA;
        else if (is_ldr || is_str)   state_d = S_GETA;
        else                         state_d = S_HALT;
      end
      S_WIMM:  state_d = S_IF1;
      S_GETA:  state_d = (is_ldr || is_str) ? S_ADDR : S_GETB;
      S_GETB:  state_d = is_str ? S_STC : S_ALU;
      S_ALU:   state_d = is_cmp ? S_IF1 : S_WREG;
      S_WREG:  state_d = S_IF1;
      S_ADDR:  state_d = S_LADDR;
      S_LADDR: begin
        da_d    = datapath_out[7:0];
        state_d = is_ldr ? S_RD1 : S_GETB;
      end
      S_RD1:   state_d = S_RD2;
      S_RD2:   state_d = S_IF1;
      S_STC:   state_d = S_WR;
      S_WR:    state_d = S_IF1;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RST;
      pc_q    <= 8'h00;
      ir_q    <= 16'h0000;
      da_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      da_q    <= da_d;
    end
  end

  always_comb begin
    bus.mem_cmd  = 2'b00;
    bus.mem_addr = pc_q;
    readnum      = 3'd0;
    writenum     = 3'd0;
    vsel         = 4'b0000;
    loada        = 1'b0;
    loadb        = 1'b0;
    loadc        = 1'b0;
    loads        = 1'b0;
    write        = 1'b0;
    asel         = 1'b0;
    bsel         = 1'b0;
    sximmsel     = 1'b0;
    shift        = 2'b00;
    ALUop        = 2'b00;
    halted       = 1'b0;
    case (state_q)
      S_IF1, S_IF2: bus.mem_cmd = 2'b01;
      S_WIMM: begin
        vsel     = 4'b0010;
        write    = 1'b1;
        writenum = rn;
      end
      S_GETA: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GETB: begin
        readnum = is_str ? rd : rm;
        loadb   = 1'b1;
      end
      S_ALU: begin
        shift = sh;
        ALUop = is_alu ? op : 2'b00;
        asel  = is_movr || is_mvn;
        loadc = !is_cmp;
        loads = is_cmp;
      end
      S_WREG: begin
        vsel     = 4'b1000;
        write    = 1'b1;
        writenum = rd;
      end
      S_ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_RD1: begin
        bus.mem_cmd  = 2'b01;
        bus.mem_addr = da_q;
      end
      S_RD2: begin
        bus.mem_cmd  = 2'b01;
        bus.mem_addr = da_q;
        vsel         = 4'b0001;
        write        = 1'b1;
        writenum     = rd;
      end
      S_STC: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      S_WR: begin
        bus.mem_cmd  = 2'b10;
        bus.mem_addr = da_q;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_cpu_control.sv
// Bench for cpu_control: a behavioural SRM datapath and memory surround the DUT,
// expected values are queued as each step is driven and popped at the compare point.
module tb_cpu_control;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] datapath_out;
  logic [7:0]  PC;
  logic [2:0]  readnum, writenum;
  logic [3:0]  vsel;
  logic        loada, loadb, loadc, loads, write;
  logic        asel, bsel, sximmsel;
  logic [1:0]  shift, ALUop;
  logic [15:0] sximm8, sximm5;
  logic        halted;

  cpu_control_if bus ();

  cpu_control u_dut (
    .clk(clk), .reset(reset), .bus(bus), .datapath_out(datapath_out),
    .PC(PC), .readnum(readnum), .writenum(writenum), .vsel(vsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .write(write),
    .asel(asel), .bsel(bsel), .sximmsel(sximmsel), .shift(shift), .ALUop(ALUop),
    .sximm8(sximm8), .sximm5(sximm5), .halted(halted)
  );

  always #5 clk = ~clk;

  // Behavioural memory (registered read) and datapath.
  logic [15:0] mem [0:255];
  logic [15:0] regs [0:7];
  logic [15:0] a_reg, b_reg, c_reg;
  logic        z_flag, n_flag, v_flag;
  logic [15:0] ain, bin, b_sh, alu_out, wdata;
  logic [15:0] store_data;

  assign datapath_out = c_reg;

  always @(posedge clk) begin
    if (bus.mem_cmd == 2'b01) bus.mem_rdata <= mem[bus.mem_addr];
    if (bus.mem_cmd == 2'b10) store_data <= datapath_out;
  end

  always_comb begin
    b_sh = b_reg;
    case (shift)
      2'b01:   b_sh = {b_reg[14:0], 1'b0};
      2'b10:   b_sh = {1'b0, b_reg[15:1]};
      2'b11:   b_sh = {b_reg[15], b_reg[15:1]};
      default: b_sh = b_reg;
    endcase
    ain = asel ? 16'h0000 : a_reg;
    bin = bsel ? (sximmsel ? sximm8 : sximm5) : b_sh;
    case (ALUop)
      2'b00:   alu_out = ain + bin;
      2'b01:   alu_out = ain - bin;
      2'b10:   alu_out = ain & bin;
      default: alu_out = ~bin;
    endcase
    wdata = 16'h0000;
    case (vsel)
      4'b0001: wdata = bus.mem_rdata;
      4'b0010: wdata = sximm8;
      4'b0100: wdata = {8'h00, PC};
      4'b1000: wdata = c_reg;
      default: wdata = 16'h0000;
    endcase
  end

  always @(posedge clk) begin
    if (write) regs[writenum] <= wdata;
    if (loada) a_reg <= regs[readnum];
    if (loadb) b_reg <= regs[readnum];
    if (loadc) c_reg <= alu_out;
    if (loads) begin
      z_flag <= (alu_out == 16'h0000);
      n_flag <= alu_out[15];
      v_flag <= (ain[15] != bin[15]) && (alu_out[15] != ain[15]);
    end
  end

  // Scoreboard.
  string       tag_q [$];
  logic [15:0] exp_q [$];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic expect_val(input string tag, input logic [15:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic check(input logic [15:0] obs);
    string       tag;
    logic [15:0] exp_v;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %h expected none", obs);
    end else begin
      tag   = tag_q.pop_front();
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
      $display("vector %0d %s observed %h", vectors, tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int ld_cnt, lc_cnt, wr_cnt, wc_cnt, bad_cnt;
  logic [7:0]  a_rd1, a_rd2, w_addr;
  logic [15:0] w_data;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
    mem[0] = 16'hD007; mem[1] = 16'hD103; mem[2] = 16'hA041; mem[3] = 16'hA800;
    mem[4] = 16'h6061; mem[5] = 16'h8022; mem[6] = 16'hE000; mem[8] = 16'hBEEF;
    step(); step();
    expect_val("rst_mem_cmd", 16'd0); check({14'd0, bus.mem_cmd});
    expect_val("rst_pc", 16'd0);      check({8'd0, PC});
    expect_val("rst_halted", 16'd0);  check({15'd0, halted});
    expect_val("rst_vsel", 16'd0);    check({12'd0, vsel});
    expect_val("rst_enables", 16'd0); check({11'd0, loada, loadb, loadc, loads, write});

    // First fetch, then reset in the ALU state of the ADD.
    reset = 1'b0; step();
    expect_val("if1_cmd", 16'd1);  check({14'd0, bus.mem_cmd});
    expect_val("if1_addr", 16'd0); check({8'd0, bus.mem_addr});
    repeat (13) step();
    expect_val("add_alu_loadc", 16'd1); check({15'd0, loadc});
    reset = 1'b1; step();
    expect_val("midrst_pc", 16'd0);    check({8'd0, PC});
    expect_val("midrst_cmd", 16'd0);   check({14'd0, bus.mem_cmd});
    expect_val("midrst_loadc", 16'd0); check({15'd0, loadc});
    reset = 1'b0; step();
    expect_val("refetch_cmd", 16'd1);  check({14'd0, bus.mem_cmd});
    expect_val("refetch_addr", 16'd0); check({8'd0, bus.mem_addr});

    // MOV, MOV, ADD: 15 cycles from first IF1.
    repeat (14) step();
    expect_val("wreg_vsel", 16'h0008);   check({12'd0, vsel});
    expect_val("wreg_writenum", 16'd2);  check({13'd0, writenum});
    step();
    expect_val("add_r2", 16'd10);   check(regs[2]);
    expect_val("add_pc", 16'd3);    check({8'd0, PC});
    expect_val("add_next_if", 16'd3); check({8'd0, bus.mem_addr});

    // CMP R0,R0: 6 cycles.
    ld_cnt = 0; lc_cnt = 0; wr_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      ld_cnt += int'(loads); lc_cnt += int'(loadc); wr_cnt += int'(write);
      step();
    end
    expect_val("cmp_loads", 16'd1);  check(16'(ld_cnt));
    expect_val("cmp_loadc", 16'd0);  check(16'(lc_cnt));
    expect_val("cmp_write", 16'd0);  check(16'(wr_cnt));
    expect_val("cmp_znv", 16'h0004); check({13'd0, z_flag, n_flag, v_flag});
    expect_val("cmp_next_if", 16'd4); check({8'd0, bus.mem_addr});

    // LDR R3,[R0,#1]: 8 cycles.
    for (int c = 0; c < 8; c++) begin
      if (c == 6) a_rd1 = bus.mem_addr;
      if (c == 7) a_rd2 = bus.mem_addr;
      step();
    end
    expect_val("ldr_rd1_addr", 16'h0008); check({8'd0, a_rd1});
    expect_val("ldr_rd2_addr", 16'h0008); check({8'd0, a_rd2});
    expect_val("ldr_r3", 16'hBEEF);       check(regs[3]);
    expect_val("ldr_sximm5", 16'h0001);   check(sximm5);
    expect_val("ldr_sximm8", 16'h0061);   check(sximm8);
    expect_val("ldr_next_if", 16'd5);     check({8'd0, bus.mem_addr});

    // STR R1,[R0,#2]: 9 cycles, one write cycle.
    wc_cnt = 0; w_addr = 8'h00; w_data = 16'h0000;
    for (int c = 0; c < 9; c++) begin
      if (bus.mem_cmd == 2'b10) begin
        wc_cnt++; w_addr = bus.mem_addr; w_data = datapath_out;
      end
      step();
    end
    expect_val("str_wr_cycles", 16'd1); check(16'(wc_cnt));
    expect_val("str_addr", 16'h0009);   check({8'd0, w_addr});
    expect_val("str_data", 16'h0003);   check(w_data);
    expect_val("str_mem_data", 16'h0003); check(store_data);
    expect_val("str_next_if", 16'd6);   check({8'd0, bus.mem_addr});

    // HALT holds with no memory traffic.
    repeat (3) step();
    bad_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (!halted || bus.mem_cmd != 2'b00) bad_cnt++;
      step();
    end
    expect_val("halt_hold", 16'd0); check(16'(bad_cnt));
    expect_val("halt_pc", 16'd7);   check({8'd0, PC});

    // Undefined encoding behaves as HALT; reset clears halted.
    reset = 1'b1; mem[0] = 16'hF800; step();
    expect_val("undef_rst_halted", 16'd0); check({15'd0, halted});
    reset = 1'b0; step();
    repeat (3) step();
    bad_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (!halted || bus.mem_cmd != 2'b00) bad_cnt++;
      step();
    end
    expect_val("undef_hold", 16'd0); check(16'(bad_cnt));
    expect_val("undef_pc", 16'd1);   check({8'd0, PC});

    // PC wrap: MOV R0,#i at every address.
    reset = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 16'hD000 | 16'(i);
    step();
    reset = 1'b0; step();
    repeat (4 * 255) step();
    expect_val("wrap_fetch_ff", 16'h00FF); check({8'd0, bus.mem_addr});
    expect_val("wrap_r0_fe", 16'hFFFE);    check(regs[0]);
    step(); step();
    expect_val("wrap_pc", 16'h0000);       check({8'd0, PC});
    expect_val("wrap_sximm8", 16'hFFFF);   check(sximm8);
    step(); step();
    expect_val("wrap_fetch_00", 16'h0000); check({8'd0, bus.mem_addr});
    expect_val("wrap_r0_ff", 16'hFFFF);    check(regs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
